char_judge: RTL and testbench
=============================

# char_judge

Round controller and answer checker for the typing game. It consumes the 5-bit letter index produced by the pseudo-random character generator and presents it as a target ASCII letter. It then waits for a keyboard keystroke, judges it as a hit or a miss (wrong letter or timeout), and keeps saturating hit and miss scores. It sits between the random generator and the keyboard decoder on one side, and the display and score logic on the other.

## Interface
- TIMEOUT_CYC, 50_000_000: cycles allowed per target before an automatic miss (must be ≥2).
- CNT_W, 8: width of the hit and miss counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled; in IDLE, begins a game.
- stop  in  1  level-sampled; forces IDLE from any state.
- rdchar  in  5  letter index from the random generator, nominally 0..25.
- key_valid  in  1  one-cycle strobe per key press.
- key_ascii  in  8  ASCII code, qualified by key_valid.
- target_ascii  out  8  current target, lowercase 'a'..'z'.
- target_valid  out  1  high while a target is awaiting input.
- hit  out  1  one-cycle pulse on a correct key.
- miss  out  1  one-cycle pulse on a wrong key or timeout.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, WAIT, RESULT.
- IDLE: if start=1, clear hit_cnt and miss_cnt, then go to LOAD.
- LOAD: latch target_ascii = 8'h61 + idx, where idx = rdchar if rdchar ≤ 25, else rdchar − 26. Clear the timer. Go to WAIT.
- WAIT:
  - target_valid = 1 and the timer increments each cycle.
  - key_valid with a letter key ('a'..'z' or 'A'..'Z', case-insensitive): compare it with the target. Register hit on a match, miss otherwise. Go to RESULT.
  - key_valid with a non-letter key: ignored. No pulse, the timer keeps running.
  - Timer reaches TIMEOUT_CYC−1 with no qualifying key: register miss and go to RESULT.
- RESULT: hit and miss are high for exactly this cycle. Go to LOAD.
- Counters increment on the edge that enters RESULT and saturate at 2^CNT_W−1.
- stop=1: go to IDLE on the next edge from any state. A keystroke in that same cycle is dropped, no pulse is produced, and counters hold.
- Priority in WAIT: stop > key_valid > timeout. A letter key arriving in the expiry cycle is judged on its own value.
- start in a non-IDLE state is ignored.

## Timing
- Reset values: state IDLE, target_ascii 8'h00, target_valid 0, hit 0, miss 0, hit_cnt 0, miss_cnt 0, busy 0, timer 0.
- Reset asserted mid-round aborts immediately. No pulse is emitted and counts are lost.
- Start to target: start sampled at edge N puts the block in LOAD. target_ascii is valid and target_valid=1 after edge N+1.
- Key to pulse: key_valid sampled at edge M drives hit or miss high during cycle M..M+1. The counter is updated at edge M.
- Next target: latched at edge M+2, valid after it.
- target_valid is low in RESULT and LOAD, a 2-cycle gap per round.
- Timeout: the timeout miss occurs TIMEOUT_CYC cycles after target_valid rises.
- All outputs are registered. No combinational input-to-output path.

## Structure
- Shared package `game_pkg`:
  - state enum.
  - ASCII_LC_A = 8'h61, ASCII_UC_A = 8'h41, LETTERS = 26.
  - the letter-index range constants, shared with the generator and display.
- Sub-module `key_to_index`, combinational. Inputs: key_ascii. Outputs: is_letter and 5-bit index. Folds case so 'A' and 'a' both map to 0.
- Timer and FSM live in char_judge.

## Test plan
Bench parameter: TIMEOUT_CYC=16.
- Reset then start with rdchar=5: target_ascii=8'h66 ('f') and target_valid=1 two edges after start is sampled.
- Target 'f', key_valid with key_ascii=8'h46 ('F'): hit pulses for one cycle, hit_cnt=1, miss_cnt=0. The next target is latched 2 edges later.
- Target 'f', key 'g': one miss pulse, miss_cnt=1. Then key 8'h31 ('1') on the next target: no pulse, target held.
- No key for 16 cycles after target_valid rises: miss pulses, miss_cnt increments. Letter key exactly in the expiry cycle: judged by its value, only one pulse.
- rdchar=29: target_ascii=8'h64 ('d'). CNT_W=2 with 5 hits: hit_cnt saturates at 3.
- stop and key_valid in the same WAIT cycle: IDLE, no pulse, counts held. clrn low mid-WAIT: all outputs return to reset values immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared typing-game definitions: round-controller states, ASCII anchors and letter-index range.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } judge_state_t;

  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_Z = 8'h5A;
  localparam int         LETTERS    = 26;

  // Letter-index range shared with the random generator and the display.
  localparam int                IDX_W       = 5;
  localparam logic [IDX_W-1:0]  IDX_MIN     = 5'd0;
  localparam logic [IDX_W-1:0]  IDX_MAX     = 5'd25;
  localparam logic [IDX_W-1:0]  LETTERS_IDX = 5'd26;

  // The generator can emit 26..31; those wrap back onto 0..5 so every
  // raw value still names a letter.
  function automatic logic [IDX_W-1:0] fold_index(input logic [IDX_W-1:0] raw);
    if (raw > IDX_MAX) begin
      return raw - LETTERS_IDX;
    end
    return raw;
  endfunction

endpackage

// File: rtl/key_to_index.sv
// Classifies a keyboard ASCII code as a letter and maps it to a case-folded 0..25 index.
// Latency: combinational. Backpressure: none.
// Ports: key_ascii (in, 8) -> is_letter (out, 1), index (out, 5; 'A' and 'a' both give 0, 0 for non-letters).
module key_to_index
  import game_pkg::*;
(
  input  logic [7:0]       key_ascii,
  output logic             is_letter,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    is_letter = 1'b0;
    index     = IDX_MIN;
    if (key_ascii >= ASCII_LC_A && key_ascii <= ASCII_LC_Z) begin
      is_letter = 1'b1;
      index     = IDX_W'(key_ascii - ASCII_LC_A);
    end else if (key_ascii >= ASCII_UC_A && key_ascii <= ASCII_UC_Z) begin
      is_letter = 1'b1;
      index     = IDX_W'(key_ascii - ASCII_UC_A);
    end
  end

endmodule

// File: rtl/char_judge.sv
// Typing-game round controller: presents a target letter, judges one keystroke or a timeout, keeps saturating scores.
// Latency: start -> target valid 2 edges; key -> hit/miss pulse 1 edge; next target 2 edges after the key.
// Backpressure: none; key_valid is a strobe, keys outside WAIT and non-letter keys are simply dropped.
// Ports: clk, clrn (async active-low); start/stop levels; rdchar (5) from generator; key_valid/key_ascii (8)
//        from keyboard; target_ascii (8), target_valid, hit, miss, hit_cnt/miss_cnt (CNT_W), busy -- all registered.
module char_judge
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             stop,
  input  logic [4:0]       rdchar,
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  output logic [7:0]       target_ascii,
  output logic             target_valid,
  output logic             hit,
  output logic             miss,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             busy
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  judge_state_t     state;
  judge_state_t     state_nxt;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] tgt_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             key_is_letter;
  logic [IDX_W-1:0] key_idx;
  logic             hit_nxt;
  logic             miss_nxt;
  logic             clr_cnt;
  logic             load_tgt;

  key_to_index u_key_to_index (
    .key_ascii (key_ascii),
    .is_letter (key_is_letter),
    .index     (key_idx)
  );

  assign rd_idx = fold_index(rdchar);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stop outranks everything, so a key in the same cycle never reaches the judge.
  // In WAIT a letter key outranks the timeout, so a key in the expiry cycle is
  // judged on its own value.
  always_comb begin
    state_nxt = state;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    clr_cnt   = 1'b0;
    load_tgt  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            clr_cnt   = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: begin
          load_tgt  = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (key_valid && key_is_letter) begin
            hit_nxt   = (key_idx == tgt_idx);
            miss_nxt  = (key_idx != tgt_idx);
            state_nxt = ST_RESULT;
          end else if (timer == TMR_LAST) begin
            miss_nxt  = 1'b1;
            state_nxt = ST_RESULT;
          end
        end
        ST_RESULT: begin
          state_nxt = ST_LOAD;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are flops loaded from the next-state decode so nothing on the
  // output pins depends combinationally on an input.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      timer        <= '0;
      tgt_idx      <= IDX_MIN;
      target_ascii <= 8'h00;
      target_valid <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      busy         <= 1'b0;
    end else begin
      hit          <= hit_nxt;
      miss         <= miss_nxt;
      target_valid <= (state_nxt == ST_WAIT);
      busy         <= (state_nxt != ST_IDLE);

      if (load_tgt) begin
        tgt_idx      <= rd_idx;
        target_ascii <= ASCII_LC_A + 8'(rd_idx);
        timer        <= '0;
      end else if (state == ST_WAIT && !stop) begin
        // WAIT is left at TMR_LAST, so the timer never wraps.
        timer <= timer + TMR_W'(1);
      end

      if (clr_cnt) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else begin
        if (hit_nxt && hit_cnt != CNT_MAX) begin
          hit_cnt <= hit_cnt + CNT_W'(1);
        end
        if (miss_nxt && miss_cnt != CNT_MAX) begin
          miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_char_judge.sv
// Self-checking bench for char_judge with a short timeout and 2-bit counters.
// Expected pulses and scores are queued when a keystroke/timeout is set up and
// compared when the DUT pulses hit or miss.
module tb_char_judge;

  localparam int T_CYC = 16;
  localparam int CW    = 2;

  logic          clk;
  logic          clrn;
  logic          start;
  logic          stop;
  logic [4:0]    rdchar;
  logic          key_valid;
  logic [7:0]    key_ascii;
  logic [7:0]    target_ascii;
  logic          target_valid;
  logic          hit;
  logic          miss;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;
  logic          busy;

  char_judge #(.TIMEOUT_CYC(T_CYC), .CNT_W(CW)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .start        (start),
    .stop         (stop),
    .rdchar       (rdchar),
    .key_valid    (key_valid),
    .key_ascii    (key_ascii),
    .target_ascii (target_ascii),
    .target_valid (target_valid),
    .hit          (hit),
    .miss         (miss),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .busy         (busy)
  );

  typedef struct packed {
    logic          h;
    logic          m;
    logic [CW-1:0] hc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rise_cyc = 0;
  logic [7:0] cur_tgt;
  logic [CW-1:0] m_hc;
  logic [CW-1:0] m_mc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] tgt_of(input logic [4:0] rd);
    int v;
    v = (rd > 25) ? int'(rd) - 26 : int'(rd);
    return 8'(97 + v);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Scoreboard consumer: every pulse cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (clrn && (hit || miss)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_hit", hit, e.h);
        check("pulse_miss", miss, e.m);
        check("hit_cnt", hit_cnt, e.hc);
        check("miss_cnt", miss_cnt, e.mc);
      end
    end
  end

  // Called at the RESULT cycle (+1ns): walks through LOAD to the next target.
  task automatic finish_round(input logic [4:0] nxt_rd);
    check("tv_low_result", target_valid, 1'b0);
    @(posedge clk); #1;
    check("pulse_gone_load", {hit, miss}, 2'b00);
    check("tv_low_load", target_valid, 1'b0);
    @(posedge clk); #1;
    cur_tgt = tgt_of(nxt_rd);
    check("next_target", target_ascii, cur_tgt);
    check("tv_next", target_valid, 1'b1);
    rise_cyc = cyc;
  endtask

  task automatic press(input logic [7:0] k, input logic [4:0] nxt_rd);
    logic [7:0] lk;
    logic       eh;
    lk = (k >= 8'h41 && k <= 8'h5A) ? k + 8'h20 : k;
    eh = (lk == cur_tgt);
    if (eh) m_hc = sat_inc(m_hc);
    else    m_mc = sat_inc(m_mc);
    sb.push_back('{h: eh, m: !eh, hc: m_hc, mc: m_mc});
    key_valid = 1'b1;
    key_ascii = k;
    rdchar    = nxt_rd;
    @(posedge clk); #1;
    key_valid = 1'b0;
    finish_round(nxt_rd);
  endtask

  task automatic press_nonletter(input logic [7:0] k);
    key_valid = 1'b1;
    key_ascii = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("nonletter_tv", target_valid, 1'b1);
    check("nonletter_tgt", target_ascii, cur_tgt);
    check("nonletter_nopulse", {hit, miss}, 2'b00);
  endtask

  task automatic await_timeout(input logic [4:0] nxt_rd);
    int n;
    logic found;
    m_mc = sat_inc(m_mc);
    sb.push_back('{h: 1'b0, m: 1'b1, hc: m_hc, mc: m_mc});
    rdchar = nxt_rd;
    n = 0;
    found = 1'b0;
    while (!found && n < 3 * T_CYC) begin
      @(posedge clk); #1;
      n++;
      if (miss) found = 1'b1;
    end
    check("timeout_seen", found, 1'b1);
    check("timeout_latency", cyc - rise_cyc, T_CYC);
    finish_round(nxt_rd);
  endtask

  task automatic begin_game(input logic [4:0] rd);
    rdchar = rd;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_tv_low", target_valid, 1'b0);
    check("start_hcnt_clr", hit_cnt, 0);
    check("start_mcnt_clr", miss_cnt, 0);
    @(posedge clk); #1;
    cur_tgt = tgt_of(rd);
    check("start_target", target_ascii, cur_tgt);
    check("start_tv", target_valid, 1'b1);
    rise_cyc = cyc;
    m_hc = '0;
    m_mc = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b0; start = 1'b0; stop = 1'b0;
    rdchar = 5'd0; key_valid = 1'b0; key_ascii = 8'h00;
    m_hc = '0; m_mc = '0; cur_tgt = 8'h00;
    #23;
    check("rst_target", target_ascii, 8'h00);
    check("rst_tv", target_valid, 1'b0);
    check("rst_pulses", {hit, miss}, 2'b00);
    check("rst_hcnt", hit_cnt, 0);
    check("rst_mcnt", miss_cnt, 0);
    check("rst_busy", busy, 1'b0);
    clrn = 1'b1;
    @(posedge clk); #1;

    begin_game(5'd5);                 // 'f'
    press(8'h46, 5'd5);               // 'F' on 'f' -> hit
    press(8'h67, 5'd29);              // 'g' on 'f' -> miss, next 29 -> 'd'
    start = 1'b1;                     // start outside IDLE must be ignored
    press_nonletter(8'h31);           // '1' ignored, timer keeps running
    start = 1'b0;
    await_timeout(5'd0);              // timeout miss, next 'a'

    repeat (T_CYC - 1) @(posedge clk);
    #1;
    check("pre_expiry_tv", target_valid, 1'b1);
    press(8'h41, 5'd31);              // 'A' in expiry cycle -> single hit, next 'f'

    press(8'h66, 5'd2);               // hit 3, next 'c'
    press(8'h43, 5'd25);              // hit saturates, next 'z'
    press(8'h7A, 5'd26);              // hit saturated, next 'a'
    press(8'h62, 5'd10);              // miss 3, next 'k'
    press(8'h5A, 5'd3);               // miss saturated, next 'd'

    // stop together with a matching key: no pulse, counts held
    stop = 1'b1; key_valid = 1'b1; key_ascii = 8'h64;
    @(posedge clk); #1;
    stop = 1'b0; key_valid = 1'b0;
    check("stop_busy", busy, 1'b0);
    check("stop_tv", target_valid, 1'b0);
    check("stop_nopulse", {hit, miss}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("stop_hcnt_held", hit_cnt, m_hc);
    check("stop_mcnt_held", miss_cnt, m_mc);

    begin_game(5'd7);                 // 'h', counters cleared
    press(8'h68, 5'd1);               // hit 1, next 'b'

    repeat (3) @(posedge clk);
    #1;
    clrn = 1'b0;
    #1;
    check("arst_target", target_ascii, 8'h00);
    check("arst_tv", target_valid, 1'b0);
    check("arst_pulses", {hit, miss}, 2'b00);
    check("arst_hcnt", hit_cnt, 0);
    check("arst_mcnt", miss_cnt, 0);
    check("arst_busy", busy, 1'b0);
    #6;
    clrn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
